// File: rtl/seq_mult_param.sv
// seq_mult_param: iterative shift-and-add multiplier with a configurable operand
// width and a per-operation signed/unsigned mode. A valid/ready handshake is used on
// both sides. The result is held in the product register while the consumer applies
// backpressure.
//
// Parameters:
//   WIDTH      operand width in bits (>= 2); the product is 2*WIDTH bits wide.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair and mode are valid
//   in_ready   an operation can be accepted (high only in IDLE)
//   a, b       multiplicand, multiplier
//   op_signed  1: two's complement operands and product; 0: unsigned
//   out_valid  product is valid (high only in DONE)
//   out_ready  consumer accepts the product
//   product    result register; it changes only in FIX
//   busy       high in CALC or FIX
//
// Optional feature:
//   SEQ_MULT_EARLY_TERM_EN  when defined, CALC also ends after any iteration that
//   leaves the shifted multiplier at zero.
module seq_mult_param #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               op_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CW-1:0]   count_q, count_d;
    logic            neg_q, neg_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [PW-1:0]   product_q, product_d;

    logic [WIDTH-1:0] a_mag, b_mag;

    // -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude.
    always_comb begin
        a_mag = (op_signed && a[WIDTH-1]) ? -a : a;
        b_mag = (op_signed && b[WIDTH-1]) ? -b : b;
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        count_d   = count_q;
        neg_d     = neg_q;
        acc_d     = acc_q;
        product_d = product_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    mcand_d  = {{WIDTH{1'b0}}, a_mag};
                    mplier_d = b_mag;
                    neg_d    = op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    acc_d    = '0;
                    count_d  = '0;
                    state_d  = StCalc;
                end
            end
            StCalc: begin
                // mcand_q is shifted one place per iteration, so it always equals
                // the latched multiplicand << count.
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + 1'b1;
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d = StFix;
                end
`ifdef SEQ_MULT_EARLY_TERM_EN
                if ((mplier_q >> 1) == '0) begin
                    state_d = StFix;
                end
`endif
            end
            StFix: begin
                product_d = neg_q ? -acc_q : acc_q;
                state_d   = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            mcand_q   <= '0;
            mplier_q  <= '0;
            count_q   <= '0;
            neg_q     <= 1'b0;
            acc_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            count_q   <= count_d;
            neg_q     <= neg_d;
            acc_q     <= acc_d;
            product_q <= product_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q == StCalc) || (state_q == StFix);
    assign product   = product_q;

endmodule

// File: tb/tb_seq_mult_param.sv
// Self-checking bench for seq_mult_param (WIDTH=8). Expected products and latencies
// come from a plain-arithmetic reference model. Define SEQ_MULT_EARLY_TERM_EN
// consistently for the bench and the design.
module tb_seq_mult_param;

    localparam int unsigned W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           op_signed;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] product;
    logic           busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seq_mult_param #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op_signed (op_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                               input logic s);
        longint p;
        if (s) p = longint'($signed(x)) * longint'($signed(y));
        else   p = longint'(x) * longint'(y);
        return p[2*W-1:0];
    endfunction

    // Cycles from the accept edge to the first cycle with out_valid high.
    function automatic int ref_lat(input logic [W-1:0] y, input logic s);
        logic [W-1:0] m;
        int h;
        m = (s && y[W-1]) ? -y : y;
        h = 0;
        for (int i = 0; i < int'(W); i++) if (m[i]) h = i;
`ifdef SEQ_MULT_EARLY_TERM_EN
        return h + 2;
`else
        return (h >= 0) ? int'(W) + 1 : 0;
`endif
    endfunction

    // Runs one operation. The consumer holds out_ready low for 'hold' cycles of DONE.
    task automatic run_op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic s, input int hold, input logic [2*W-1:0] exp_p);
        int  exp_lat, lat, busy_cnt;
        bit  seen;
        exp_lat = ref_lat(bv, s);
        @(negedge clk);
        a = av; b = bv; op_signed = s; in_valid = 1'b1; out_ready = (hold == 0);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL %s in_ready_pre: got %b want 1", name, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; a = W'($urandom); b = W'($urandom); op_signed = 1'($urandom);
        lat = 0; busy_cnt = 0; seen = 0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                seen = 1;
            end else begin
                lat++;
                if (busy === 1'b1) busy_cnt++;
                a = W'($urandom); b = W'($urandom);
            end
        end
        n_checks++;
        if (!seen) begin
            n_errors++;
            $display("FAIL %s timeout: out_valid never rose, want within %0d", name, exp_lat);
            return;
        end
        n_checks++;
        if (lat != exp_lat) begin
            n_errors++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
        end
        n_checks++;
        if (busy_cnt != exp_lat) begin
            n_errors++;
            $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_cnt, exp_lat);
        end
        n_checks++;
        if (product !== exp_p || in_ready !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL %s product: got %h (in_ready %b busy %b) want %h (0 0)",
                     name, product, in_ready, busy, exp_p);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || product !== exp_p || in_ready !== 1'b0) begin
                n_errors++;
                $display("FAIL %s hold%0d: got valid %b prod %h rdy %b want 1 %h 0",
                         name, i, out_valid, product, in_ready, exp_p);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || product !== exp_p) begin
            n_errors++;
            $display("FAIL %s release: got valid %b rdy %b prod %h want 0 1 %h",
                     name, out_valid, in_ready, product, exp_p);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op_signed = 1'b0; out_ready = 1'b0;
        #12;
        n_checks++;
        if (out_valid !== 1'b0 || product !== '0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_state: got valid %b prod %h busy %b want 0 0000 0",
                     out_valid, product, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_release: got rdy %b valid %b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        run_op("u255x255", 8'hFF, 8'hFF, 1'b0, 0, 16'hFE01);
        run_op("s_m3x5",   8'hFD, 8'h05, 1'b1, 0, 16'hFFF1);
        run_op("s_m128sq", 8'h80, 8'h80, 1'b1, 0, 16'h4000);
        run_op("s_m128x1", 8'h80, 8'h01, 1'b1, 0, 16'hFF80);
        run_op("u128sq",   8'h80, 8'h80, 1'b0, 0, 16'h4000);
        run_op("u200x1",   8'd200, 8'd1, 1'b0, 0, 16'h00C8);
        run_op("u200x0",   8'd200, 8'd0, 1'b0, 0, 16'h0000);
    endtask

    task automatic test_backpressure();
        run_op("bp_7x6", 8'd7, 8'd6, 1'b0, 5, 16'h002A);
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk);
        a = 8'd100; b = 8'd100; op_signed = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_errors++;
            $display("FAIL rst_mid_busy: got %b want 1", busy);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || product !== '0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_mid_state: got valid %b prod %h busy %b want 0 0000 0",
                     out_valid, product, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== '0) begin
            n_errors++;
            $display("FAIL rst_mid_release: got rdy %b valid %b prod %h want 1 0 0000",
                     in_ready, out_valid, product);
        end
        run_op("rst_2x3", 8'd2, 8'd3, 1'b0, 0, 16'h0006);
    endtask

    task automatic test_back_to_back();
        bit seen;
        int lat;
        @(negedge clk);
        a = 8'd12; b = 8'd12; op_signed = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        seen = 0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1;
        end
        n_checks++;
        if (!seen || product !== 16'h0090) begin
            n_errors++;
            $display("FAIL b2b_first: got seen %0d prod %h want 1 0090", seen, product);
        end
        a = 8'd13; b = 8'd13;
        @(negedge clk);
        // Handshake edge must return to IDLE, not accept the held request.
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_gap: got rdy %b busy %b valid %b want 1 0 0",
                     in_ready, busy, out_valid);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        seen = 0; lat = 0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1;
            else lat++;
        end
        n_checks++;
        if (!seen || product !== 16'h00A9 || lat != ref_lat(8'd13, 1'b0)) begin
            n_errors++;
            $display("FAIL b2b_second: got seen %0d prod %h lat %0d want 1 00a9 %0d",
                     seen, product, lat, ref_lat(8'd13, 1'b0));
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [W-1:0] ra, rb;
        logic         rs;
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if (i % 8 == 0) rb = W'($urandom_range(0, 3));
            rs = 1'($urandom);
            run_op($sformatf("rand%0d", i), ra, rb, rs, int'($urandom_range(0, 3)),
                   ref_mul(ra, rb, rs));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
